// File: rtl/collision_pkg.sv
// Shared types for the collision scheduler: FSM states, coordinates and boxes.
package collision_pkg;

  localparam int unsigned COORD_W_DEF = 12;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;

  typedef struct packed {
    coord_t left;
    coord_t right;
    coord_t top;
    coord_t bottom;
  } box_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/next_alive_idx.sv
// Combinational priority finder: lowest set mask bit strictly above base,
// or the lowest set bit overall when first is high.
module next_alive_idx #(
  parameter int unsigned N_ALIENS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic [N_ALIENS-1:0] mask,
  input  logic [IDX_W-1:0]    base,
  input  logic                first,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);

  // Walk from the top down so the lowest qualifying bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = int'(N_ALIENS) - 1; i >= 0; i--) begin
      if (mask[i] && (first || (IDX_W'(i) > base))) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Time-multiplexed bullet-vs-alien overlap scanner, one scan per frame.
// Optional build macro COLLISION_MULTI_HIT_EN: piercing bullet, every
// overlapping alive slot is reported instead of stopping at the first.
// COORD_W must match collision_pkg::COORD_W_DEF (box storage width).
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int unsigned N_ALIENS = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned COORD_W  = COORD_W_DEF
) (
  input  logic                       pixel_clk,
  input  logic                       rst,
  input  logic                       fsync,
  input  logic                       bullet_active,
  input  logic signed [COORD_W-1:0]  bullet_left,
  input  logic signed [COORD_W-1:0]  bullet_right,
  input  logic signed [COORD_W-1:0]  bullet_top,
  input  logic signed [COORD_W-1:0]  bullet_bottom,
  input  logic [N_ALIENS-1:0]        alien_alive,
  output logic                       alien_rd_en,
  output logic [IDX_W-1:0]           alien_rd_idx,
  input  logic signed [COORD_W-1:0]  alien_lhpos,
  input  logic signed [COORD_W-1:0]  alien_rhpos,
  input  logic signed [COORD_W-1:0]  alien_tvpos,
  input  logic signed [COORD_W-1:0]  alien_bvpos,
  output logic                       hit_valid,
  output logic [IDX_W-1:0]           hit_idx,
  output logic                       busy,
  output logic                       scan_done,
  output logic                       frame_overrun
);

  state_t              state, state_d;
  box_t                box_q;
  logic [N_ALIENS-1:0] mask_q;
  logic                cmp_valid, cmp_valid_d;
  logic [IDX_W-1:0]    cmp_idx;
  logic                latch;

  logic                rd_en_d;
  logic [IDX_W-1:0]    rd_idx_d;
  logic                hit_valid_d;
  logic [IDX_W-1:0]    hit_idx_d;
  logic                scan_done_d;
  logic                overrun_d;
  logic                busy_d;

  logic                find_first;
  logic [N_ALIENS-1:0] find_mask;
  logic [IDX_W-1:0]    find_idx;
  logic                find_found;
  logic                hit_c;

  // In IDLE search the live mask for the first slot; while scanning use the latched copy.
  assign find_first = (state == IDLE);
  assign find_mask  = find_first ? alien_alive : mask_q;

  next_alive_idx #(
    .N_ALIENS (N_ALIENS),
    .IDX_W    (IDX_W)
  ) u_next_alive_idx (
    .mask  (find_mask),
    .base  (alien_rd_idx),
    .first (find_first),
    .idx   (find_idx),
    .found (find_found)
  );

  // Overlap compare on the read data returned for the previous issue; edges count.
  assign hit_c = cmp_valid
              && (coord_t'(box_q.right)  >= coord_t'(alien_lhpos))
              && (coord_t'(box_q.left)   <= coord_t'(alien_rhpos))
              && (coord_t'(box_q.bottom) >= coord_t'(alien_tvpos))
              && (coord_t'(box_q.top)    <= coord_t'(alien_bvpos));

  // Next-state and next-output logic for the issue/compare pipeline.
  always_comb begin
    state_d     = state;
    rd_en_d     = 1'b0;
    rd_idx_d    = alien_rd_idx;
    hit_valid_d = 1'b0;
    hit_idx_d   = hit_idx;
    scan_done_d = 1'b0;
    overrun_d   = 1'b0;
    cmp_valid_d = 1'b0;
    latch       = 1'b0;

    case (state)
      IDLE: begin
        if (fsync) begin
          if (scan_done) begin
            overrun_d = 1'b1;
          end else if (bullet_active && find_found) begin
            latch    = 1'b1;
            state_d  = SCAN;
            rd_en_d  = 1'b1;
            rd_idx_d = find_idx;
          end else begin
            scan_done_d = 1'b1;
          end
        end
      end

      SCAN: begin
        overrun_d   = fsync;
        cmp_valid_d = 1'b1;
        if (find_found) begin
          rd_en_d  = 1'b1;
          rd_idx_d = find_idx;
        end else begin
          state_d = DRAIN;
        end
        if (hit_c) begin
          hit_valid_d = 1'b1;
          hit_idx_d   = cmp_idx;
`ifdef COLLISION_MULTI_HIT_EN
          // Piercing bullet: keep issuing, each overlap gets its own pulse.
`else
          state_d     = IDLE;
          rd_en_d     = 1'b0;
          cmp_valid_d = 1'b0;
          scan_done_d = 1'b1;
`endif
        end
      end

      DRAIN: begin
        overrun_d   = fsync;
        scan_done_d = 1'b1;
        state_d     = IDLE;
        if (hit_c) begin
          hit_valid_d = 1'b1;
          hit_idx_d   = cmp_idx;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, latched frame inputs, pipeline and registered outputs.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      box_q         <= '0;
      mask_q        <= '0;
      cmp_valid     <= 1'b0;
      cmp_idx       <= '0;
      alien_rd_en   <= 1'b0;
      alien_rd_idx  <= '0;
      hit_valid     <= 1'b0;
      hit_idx       <= '0;
      busy          <= 1'b0;
      scan_done     <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_d;
      cmp_valid     <= cmp_valid_d;
      cmp_idx       <= alien_rd_idx;
      alien_rd_en   <= rd_en_d;
      alien_rd_idx  <= rd_idx_d;
      hit_valid     <= hit_valid_d;
      hit_idx       <= hit_idx_d;
      busy          <= busy_d;
      scan_done     <= scan_done_d;
      frame_overrun <= overrun_d;
      if (latch) begin
        box_q.left   <= coord_t'(bullet_left);
        box_q.right  <= coord_t'(bullet_right);
        box_q.top    <= coord_t'(bullet_top);
        box_q.bottom <= coord_t'(bullet_bottom);
        mask_q       <= alien_alive;
      end
    end
  end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Time-multiplexes one bullet-vs-box overlap check across up to N_ALIENS aliens once per frame.
- Starts on the fsync pulse. Latches the bullet box and the alive mask, then walks the alive aliens through a latency-1 position-read port.
- Reports the first hit as an index, which the alien manager uses to kill the alien and retire the bullet.
- Sits between the bullet/alien state blocks and the score/explosion logic.

Parameters:
- N_ALIENS, 16, number of alien slots.
- IDX_W, 4, index width; must satisfy 2**IDX_W >= N_ALIENS.
- COORD_W, 12, signed coordinate width.

Ports:
- pixel_clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- fsync  in  1  one-cycle frame-start pulse.
- bullet_active  in  1  bullet in flight.
- bullet_left/right/top/bottom  in  COORD_W each, signed  bullet box, inclusive bounds.
- alien_alive  in  N_ALIENS  alive mask; bit i = slot i.
- alien_rd_en  out  1  position read request.
- alien_rd_idx  out  IDX_W  slot being read.
- alien_lhpos/rhpos/tvpos/bvpos  in  COORD_W each, signed  box of slot alien_rd_idx; valid the cycle after alien_rd_en.
- hit_valid  out  1  one-cycle hit pulse.
- hit_idx  out  IDX_W  slot hit; held until the next hit.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse when a scan ends (hit or exhausted).
- frame_overrun  out  1  one-cycle pulse when fsync arrives while busy.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs 0; hit_idx 0; latched bullet box and mask 0.
  - Takes effect mid-scan; any in-flight read data is discarded.
- States are IDLE, SCAN, DRAIN.
- IDLE:
  - fsync=1 with bullet_active=1 and any alive bit set: latch the bullet box and alive mask, go to SCAN.
  - Otherwise stay in IDLE. If fsync=1 and there is nothing to scan, pulse scan_done the next cycle.
- SCAN (issue stage):
  - Each cycle, assert alien_rd_en with alien_rd_idx = lowest set bit of the latched mask above the previous index (first cycle: lowest set bit).
  - Dead slots cost zero cycles.
  - After issuing the highest alive index, go to DRAIN.
- Compare stage (SCAN and DRAIN), one cycle behind issue:
  - hit = (bullet_right >= lhpos) && (bullet_left <= rhpos) && (bullet_bottom >= tvpos) && (bullet_top <= bvpos).
  - Compare is signed and edges count as overlap.
- Hit:
  - Registered: hit_valid=1 and hit_idx=idx one cycle after the compare.
  - The scan stops and any in-flight read is dropped.
  - scan_done pulses in the same cycle as hit_valid; state returns to IDLE.
- DRAIN:
  - Compares the last read.
  - On no hit, scan_done pulses and state returns to IDLE.
- Latency:
  - fsync sampled at edge k gives the first alien_rd_en after edge k.
  - The hit for the p-th alive slot (p from 0) is reported after edge k+2+p.
  - A full miss gives scan_done after edge k+1+A, where A is the alive count.
- fsync while busy or in the scan_done cycle: ignored, and frame_overrun pulses.
- Inputs changing during a scan (bullet_active, bullet coordinates, alien_alive) have no effect; the latched copies are used.
- busy=1 from the first SCAN cycle through the final compare cycle.
- Worst case A=N_ALIENS needs N_ALIENS+2 cycles; this must be far below one frame.

Optional Feature:
- COLLISION_MULTI_HIT_EN (piercing bullet).
- When defined:
  - The scan does not stop on a hit; every overlapping alive slot produces its own hit_valid pulse, in ascending index order.
  - scan_done pulses only after the last compare, in the same cycle as the final hit if that compare hit.
- When undefined: stops on the first hit, as described above.

Decomposition:
- Package collision_pkg holds:
  - the state enum (IDLE, SCAN, DRAIN),
  - typedef coord_t (signed COORD_W),
  - struct box_t {left, right, top, bottom}.
- Sub-module next_alive_idx: combinational priority finder returning the lowest set mask bit above a given index, plus a found flag.
- The overlap compare stays inline.

Test Plan:
- Single hit:
  - Stimulus: bullet box 100..103 x 200..207, alien_alive=16'h0001, alien 0 box 98..113 x 200..215.
  - Response: hit_valid one cycle after edge k+2, hit_idx=0, scan_done in the same cycle.
- Skip dead slots:
  - Stimulus: alien_alive=16'h8101, overlapping box on slot 15 only.
  - Response: alien_rd_idx sequence 0,8,15 on consecutive cycles; hit_idx=15 after edge k+4.
- Miss and edge touch:
  - Stimulus: bullet_right=99 vs lhpos=100.
  - Response: no hit, scan_done after edge k+1+A.
  - Then set bullet_right=100: hit.
- Signed coordinates:
  - Stimulus: alien box -8..7 (partly off-screen), bullet box -2..1.
  - Response: hit.
- Overrun and reset:
  - fsync again 2 cycles into a 16-alien scan: frame_overrun pulses once and the scan is unaffected.
  - rst asserted mid-scan: all outputs 0 immediately and no further hit_valid.
- COLLISION_MULTI_HIT_EN defined:
  - Stimulus: slots 3 and 9 both overlap.
  - Response: hit_valid pulses with hit_idx 3, then 9, and scan_done aligns with the final compare.
